// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters onto one shared combinational ALU.
// Two pipeline stages: E (operands driving the ALU) and W (registered response).
module alu_issue_arbiter #(
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iReqValid0,
    output logic            oReqReady0,
    input  logic [3:0]      iReqOp0,
    input  logic [XLEN-1:0] iReqA0,
    input  logic [XLEN-1:0] iReqB0,
    input  logic [TAGW-1:0] iReqTag0,
    input  logic            iReqValid1,
    output logic            oReqReady1,
    input  logic [3:0]      iReqOp1,
    input  logic [XLEN-1:0] iReqA1,
    input  logic [XLEN-1:0] iReqB1,
    input  logic [TAGW-1:0] iReqTag1,
    output logic [3:0]      oAluOP,
    output logic [XLEN-1:0] oAluA,
    output logic [XLEN-1:0] oAluB,
    input  logic [XLEN-1:0] iAluC,
    output logic            oRspValid,
    input  logic            iRspReady,
    output logic [XLEN-1:0] oRspC,
    output logic [TAGW-1:0] oRspTag,
    output logic            oRspId,
    output logic            oRspErr,
    output logic            oBusy
);

    logic            r_ptr;
    logic            r_eValid;
    logic [3:0]      r_eOp;
    logic [XLEN-1:0] r_eA;
    logic [XLEN-1:0] r_eB;
    logic [TAGW-1:0] r_eTag;
    logic            r_eId;
    logic            r_eErr;
    logic            r_wValid;
    logic [XLEN-1:0] r_wC;
    logic [TAGW-1:0] r_wTag;
    logic            r_wId;
    logic            r_wErr;

    logic            w_wAdv;
    logic            w_eLoad;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_accept0;
    logic            w_accept1;
    logic            w_accept;
    logic            w_selId;
    logic [3:0]      w_selOp;
    logic [XLEN-1:0] w_selA;
    logic [XLEN-1:0] w_selB;
    logic [TAGW-1:0] w_selTag;
    logic            w_selErr;

    // Pipeline flow control and round-robin grant; ready is masked during reset.
    always_comb begin
        w_wAdv    = ~r_wValid | iRspReady;
        w_eLoad   = ~r_eValid | w_wAdv;
        w_grant0  = iReqValid0 & (~iReqValid1 | ~r_ptr);
        w_grant1  = iReqValid1 & (~iReqValid0 | r_ptr);
        w_accept0 = w_grant0 & w_eLoad & ~iRst;
        w_accept1 = w_grant1 & w_eLoad & ~iRst;
        w_accept  = w_accept0 | w_accept1;
        w_selId   = w_accept1;
        w_selOp   = w_selId ? iReqOp1  : iReqOp0;
        w_selA    = w_selId ? iReqA1   : iReqA0;
        w_selB    = w_selId ? iReqB1   : iReqB0;
        w_selTag  = w_selId ? iReqTag1 : iReqTag0;
        w_selErr  = (w_selOp > 4'd9);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_selId;
        end
    end

    // Illegal ops are squashed to add 0,0 so their encoding never reaches the ALU.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_eValid <= 1'b0;
            r_eOp    <= '0;
            r_eA     <= '0;
            r_eB     <= '0;
            r_eTag   <= '0;
            r_eId    <= 1'b0;
            r_eErr   <= 1'b0;
        end else if (w_eLoad) begin
            r_eValid <= w_accept;
            if (w_accept) begin
                r_eOp  <= w_selErr ? 4'd0 : w_selOp;
                r_eA   <= w_selErr ? '0 : w_selA;
                r_eB   <= w_selErr ? '0 : w_selB;
                r_eTag <= w_selTag;
                r_eId  <= w_selId;
                r_eErr <= w_selErr;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_wValid <= 1'b0;
            r_wC     <= '0;
            r_wTag   <= '0;
            r_wId    <= 1'b0;
            r_wErr   <= 1'b0;
        end else if (w_wAdv) begin
            r_wValid <= r_eValid;
            if (r_eValid) begin
                r_wC   <= r_eErr ? '0 : iAluC;
                r_wTag <= r_eTag;
                r_wId  <= r_eId;
                r_wErr <= r_eErr;
            end
        end
    end

    assign oReqReady0 = w_accept0;
    assign oReqReady1 = w_accept1;
    assign oAluOP     = r_eOp;
    assign oAluA      = r_eA;
    assign oAluB      = r_eB;
    assign oRspValid  = r_wValid;
    assign oRspC      = r_wC;
    assign oRspTag    = r_wTag;
    assign oRspId     = r_wId;
    assign oRspErr    = r_wErr;
    assign oBusy      = r_eValid | r_wValid;

endmodule
